// File: rtl/inidata_pkg.sv
// rtl/inidata_pkg.sv - shared defaults, FSM state and beat field offsets for the INIDATA sequencer.
// Used by inidata_seq and inidata_seq_if.
package inidata_pkg;

  localparam int DATA_W_DEF = 512;
  localparam int CNT_W_DEF  = 8;
  localparam int HALO_DEF   = 2;

  // Six 64-bit physics fields packed into bits [511:128] of each beat.
  localparam int FIELD_W   = 64;
  localparam int R_LSB     = 128;
  localparam int ALPHA_LSB = 192;
  localparam int K_LSB     = 256;
  localparam int PHI_LSB   = 320;
  localparam int PI_M_LSB  = 384;
  localparam int PSI_LSB   = 448;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWEEP = 2'd3
  } state_t;

endpackage

// File: rtl/inidata_seq_if.sv
// rtl/inidata_seq_if.sv - upstream beat stream, buffer write port and calc read handshake.
// master = environment side, slave = sequencer side.
interface inidata_seq_if
  import inidata_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] cal_in_data;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output in_valid, in_data, rd_ready,
    input  in_ready, cal_in_data, wr_cnt, rd_cnt, rd_valid
  );

  modport slave (
    input  in_valid, in_data, rd_ready,
    output in_ready, cal_in_data, wr_cnt, rd_cnt, rd_valid
  );
endinterface

// File: rtl/inidata_seq.sv
// rtl/inidata_seq.sv - load/drain/sweep sequencer feeding a stencil buffer and its calc stage.
// Optional INIDATA_SEQ_OVERLAP_EN: sweep reads start as soon as each stencil window has landed.
module inidata_seq
  import inidata_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int HALO   = HALO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pts,
  inidata_seq_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam logic [CNT_W-1:0] MIN_PTS = CNT_W'(2 * HALO + 1);
  localparam logic [CNT_W-1:0] HALO_C  = CNT_W'(HALO);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] cal_in_data_q, cal_in_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_ready, rd_valid, accept, xfer;

`ifdef INIDATA_SEQ_OVERLAP_EN
  // Count of beats already written into the buffer (accepts lag by the write latency).
  logic [CNT_W-1:0] landed_q, landed_d;
  assign rd_valid = ((state_q == ST_LOAD) || (state_q == ST_SWEEP)) &&
                    (({1'b0, rd_cnt_q} + {1'b0, HALO_C}) < {1'b0, landed_q});
`else
  assign rd_valid = (state_q == ST_SWEEP);
`endif

  assign in_ready = (state_q == ST_LOAD);
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = rd_valid && bus.rd_ready;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    last_d        = last_q;
    acc_cnt_d     = acc_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    cal_in_data_d = cal_in_data_q;
    err_d         = err_q;
    done_d        = 1'b0;
`ifdef INIDATA_SEQ_OVERLAP_EN
    landed_d      = landed_q;
`endif

    if (accept) begin
      cal_in_data_d = bus.in_data;
      wr_cnt_d      = acc_cnt_q;
      acc_cnt_d     = acc_cnt_q + ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_pts >= MIN_PTS) begin
            state_d   = ST_LOAD;
            n_d       = num_pts;
            last_d    = num_pts - ONE - HALO_C;
            acc_cnt_d = '0;
            rd_cnt_d  = HALO_C;
            err_d     = 1'b0;
`ifdef INIDATA_SEQ_OVERLAP_EN
            landed_d  = '0;
`endif
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
`ifdef INIDATA_SEQ_OVERLAP_EN
        landed_d = acc_cnt_q;
        if (accept && (acc_cnt_q == n_q - ONE)) state_d = ST_SWEEP;
`else
        if (accept && (acc_cnt_q == n_q - ONE)) state_d = ST_DRAIN;
`endif
      end
      ST_DRAIN: state_d = ST_SWEEP;
      ST_SWEEP: begin
`ifdef INIDATA_SEQ_OVERLAP_EN
        landed_d = acc_cnt_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Final window hands back to IDLE; rd_cnt is left on the last index.
    if (xfer) begin
      if (rd_cnt_q == last_q) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + ONE;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      n_q           <= '0;
      last_q        <= '0;
      acc_cnt_q     <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      cal_in_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef INIDATA_SEQ_OVERLAP_EN
      landed_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      last_q        <= last_d;
      acc_cnt_q     <= acc_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      cal_in_data_q <= cal_in_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
`ifdef INIDATA_SEQ_OVERLAP_EN
      landed_q      <= landed_d;
`endif
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_cnt      = rd_cnt_q;
  assign bus.wr_cnt      = wr_cnt_q;
  assign bus.cal_in_data = cal_in_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule
